// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Next-PC controller for the fetch stage. Produces the registered next_pc that
// feeds the fetch PC register. It handles the boot cycle after reset,
// sequential increment, stall hold, and branch/jump redirect. After a redirect
// it inserts wrong-path bubbles by holding fetch_valid low. It also handles
// halt/resume.
//
// Parameters:
//   RESET_VECTOR  - first fetch address after reset
//   PC_STEP       - byte increment per sequential fetch
//   FLUSH_BUBBLES - cycles fetch_valid stays low after a redirect (1..7)
//
// Ports:
//   clk            in   system clock, all state updates on posedge
//   rst            in   asynchronous active-high reset
//   stall          in   decode not accepting, hold next_pc
//   redirect       in   branch/jump taken, load redirect_pc
//   redirect_pc    in   redirect target byte address (32 bits)
//   halt           in   stop fetching (pulse or level)
//   resume         in   leave the halted state (pulse)
//   next_pc        out  registered address to the fetch PC register
//   fetch_valid    out  instruction at fetch output is consumable
//   halted         out  high while halted
//   misalign_fault out  sticky misaligned-redirect fault
//                       (only with FETCH_SEQ_ALIGN_CHECK_EN)
//
// Optional feature macro: FETCH_SEQ_ALIGN_CHECK_EN
//   When this macro is defined, a redirect to a target that is not word-aligned
//   is not loaded. Instead it sets the sticky misalign_fault and halts fetch.
//   Resume is ignored until rst clears the fault.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int unsigned PC_STEP       = 4,
    parameter int unsigned FLUSH_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] next_pc,
    output logic        fetch_valid,
    output logic        halted
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    ,
    output logic        misalign_fault
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH,
        ST_HALTED
    } state_t;

    localparam logic [31:0] STEP    = 32'(PC_STEP);
    localparam logic [2:0]  BUBBLES = 3'(FLUSH_BUBBLES);

    state_t      state;
    state_t      state_n;
    logic [31:0] pc_n;
    logic        valid_n;
    logic [2:0]  bub_cnt;
    logic [2:0]  cnt_n;
    logic        bad_target;
    logic        resume_ok;

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    logic fault_q;

    assign bad_target = (redirect_pc[1:0] != 2'b00);
    // A latched fault pins the sequencer in HALTED until reset.
    assign resume_ok  = resume & ~fault_q;

    // Sticky fault: set by any misaligned redirect the FSM acts on (never in BOOT).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect && bad_target && (state != ST_BOOT)) begin
            fault_q <= 1'b1;
        end
    end

    assign misalign_fault = fault_q;
`else
    assign bad_target = 1'b0;
    assign resume_ok  = resume;
`endif

    assign halted = (state == ST_HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_BOOT;
            next_pc     <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            bub_cnt     <= 3'd0;
        end else begin
            state       <= state_n;
            next_pc     <= pc_n;
            fetch_valid <= valid_n;
            bub_cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = next_pc;
        valid_n = fetch_valid;
        cnt_n   = bub_cnt;

        case (state)
            // Single settling cycle; every control input is ignored here.
            ST_BOOT: begin
                state_n = ST_RUN;
            end

            // RUN and FLUSH share the redirect > halt > stall priority. They
            // differ only in how a non-stalled advance treats fetch_valid.
            ST_RUN, ST_FLUSH: begin
                if (redirect && bad_target) begin
                    state_n = ST_HALTED;
                    valid_n = 1'b0;
                    cnt_n   = 3'd0;
                end else if (redirect) begin
                    pc_n    = redirect_pc;
                    cnt_n   = BUBBLES;
                    valid_n = 1'b0;
                    state_n = ST_FLUSH;
                end else if (halt) begin
                    state_n = ST_HALTED;
                    valid_n = 1'b0;
                    cnt_n   = 3'd0;
                end else if (!stall) begin
                    pc_n = next_pc + STEP;
                    if (state == ST_RUN) begin
                        valid_n = 1'b1;
                    end else if (bub_cnt <= 3'd1) begin
                        // Last wrong-path slot consumed; the next fetch is real.
                        valid_n = 1'b1;
                        cnt_n   = 3'd0;
                        state_n = ST_RUN;
                    end else begin
                        cnt_n = bub_cnt - 3'd1;
                    end
                end
            end

            // A redirect alone only sets the resume address. Combined with
            // resume, it restarts fetch through a normal flush.
            ST_HALTED: begin
                valid_n = 1'b0;
                if (redirect && bad_target) begin
                    state_n = ST_HALTED;
                end else if (redirect && resume_ok) begin
                    pc_n    = redirect_pc;
                    cnt_n   = BUBBLES;
                    state_n = ST_FLUSH;
                end else if (redirect) begin
                    pc_n = redirect_pc;
                end else if (resume_ok) begin
                    valid_n = 1'b1;
                    state_n = ST_RUN;
                end
            end

            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Drives two sequencers from the same stimulus. Instance A uses the default
// parameters. Instance B uses RESET_VECTOR=0x1000, PC_STEP=8 and
// FLUSH_BUBBLES=3. The run starts with directed scenarios and continues with
// randomized traffic that includes occasional mid-run resets. Both instances
// are compared every cycle against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    localparam logic [31:0] B_VECTOR  = 32'h0000_1000;
    localparam logic [31:0] B_STEP    = 32'd8;
    localparam int          B_BUBBLES = 3;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        resume;

    logic [31:0] a_pc, b_pc;
    logic        a_valid, b_valid;
    logic        a_halted, b_halted;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    logic        a_fault, b_fault;
`endif

    int check_count = 0;
    int fail_count  = 0;

    fetch_sequencer dut_a (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .resume        (resume),
        .next_pc       (a_pc),
        .fetch_valid   (a_valid),
        .halted        (a_halted)
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        ,
        .misalign_fault(a_fault)
`endif
    );

    fetch_sequencer #(
        .RESET_VECTOR (B_VECTOR),
        .PC_STEP      (8),
        .FLUSH_BUBBLES(3)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .resume        (resume),
        .next_pc       (b_pc),
        .fetch_valid   (b_valid),
        .halted        (b_halted)
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        ,
        .misalign_fault(b_fault)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural view of one sequencer: where fetch points, how many
    // wrong-path slots are still owed, and whether it is booting/halted/faulted.
    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [7:0]  owed;
        logic        booting;
        logic        stopped;
        logic        fault;
    } ref_t;

    ref_t ref_a, ref_b;

    function automatic ref_t refReset(input logic [31:0] vector);
        ref_t r;
        r.pc      = vector;
        r.valid   = 1'b0;
        r.owed    = 8'd0;
        r.booting = 1'b1;
        r.stopped = 1'b0;
        r.fault   = 1'b0;
        return r;
    endfunction

    function automatic ref_t refStep(input ref_t s, input logic st, input logic rd,
                                     input logic [31:0] rpc, input logic hl,
                                     input logic rs, input logic [31:0] step,
                                     input int bubbles);
        ref_t n = s;
        logic bad = ALIGN_EN && (rpc[1:0] != 2'b00);
        logic may_resume = rs && !s.fault;
        if (s.booting) begin
            n.booting = 1'b0;
            return n;
        end
        if (rd) begin
            if (bad) begin
                n.fault   = 1'b1;
                n.stopped = 1'b1;
                n.valid   = 1'b0;
                n.owed    = 8'd0;
            end else if (s.stopped && !may_resume) begin
                n.pc = rpc;
            end else begin
                n.pc      = rpc;
                n.owed    = 8'(bubbles);
                n.valid   = 1'b0;
                n.stopped = 1'b0;
            end
            return n;
        end
        if (s.stopped) begin
            if (may_resume) begin
                n.stopped = 1'b0;
                n.valid   = 1'b1;
            end
            return n;
        end
        if (hl) begin
            n.stopped = 1'b1;
            n.valid   = 1'b0;
            n.owed    = 8'd0;
            return n;
        end
        if (st) return n;
        n.pc = s.pc + step;
        if (s.owed > 8'd1) begin
            n.owed = s.owed - 8'd1;
        end else begin
            n.owed  = 8'd0;
            n.valid = 1'b1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic compareModels();
        checkOutput("A.next_pc", a_pc, ref_a.pc);
        checkOutput("A.fetch_valid", 32'(a_valid), 32'(ref_a.valid));
        checkOutput("A.halted", 32'(a_halted), 32'(ref_a.stopped));
        checkOutput("B.next_pc", b_pc, ref_b.pc);
        checkOutput("B.fetch_valid", 32'(b_valid), 32'(ref_b.valid));
        checkOutput("B.halted", 32'(b_halted), 32'(ref_b.stopped));
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        checkOutput("A.misalign_fault", 32'(a_fault), 32'(ref_a.fault));
        checkOutput("B.misalign_fault", 32'(b_fault), 32'(ref_b.fault));
`endif
    endtask

    // Called just after a negedge: drives one cycle of inputs, advances the
    // models at the posedge and compares on the following negedge.
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                                 input logic hl, input logic rs);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        resume      = rs;
        @(posedge clk);
        ref_a = refStep(ref_a, st, rd, rpc, hl, rs, 32'd4, 1);
        ref_b = refStep(ref_b, st, rd, rpc, hl, rs, B_STEP, B_BUBBLES);
        @(negedge clk);
        compareModels();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Reset is asserted between edges, so the check 1ns later proves it acts
    // asynchronously.
    task automatic resetDut();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        resume      = 1'b0;
        rst         = 1'b1;
        ref_a       = refReset(32'h0);
        ref_b       = refReset(B_VECTOR);
        #1;
        compareModels();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expectA(input string tag, input logic [31:0] pc, input logic valid,
                           input logic hlt);
        checkOutput({tag, ".pc"}, a_pc, pc);
        checkOutput({tag, ".valid"}, 32'(a_valid), 32'(valid));
        checkOutput({tag, ".halted"}, 32'(a_halted), 32'(hlt));
    endtask

    initial begin
        logic [31:0] rpc;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        resume      = 1'b0;
        ref_a       = refReset(32'h0);
        ref_b       = refReset(B_VECTOR);
        @(negedge clk);

        // Reset release and boot sequence.
        resetDut();
        expectA("reset", 32'h0, 1'b0, 1'b0);
        idle();
        expectA("boot", 32'h0, 1'b0, 1'b0);
        idle();
        expectA("seq4", 32'h4, 1'b1, 1'b0);
        idle();
        expectA("seq8", 32'h8, 1'b1, 1'b0);
        idle();
        expectA("seqC", 32'hC, 1'b1, 1'b0);
        idle();
        expectA("seq10", 32'h10, 1'b1, 1'b0);

        // Redirect with one bubble.
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        expectA("redir", 32'h100, 1'b0, 1'b0);
        idle();
        expectA("redir_next", 32'h104, 1'b1, 1'b0);

        // Stall hold at 0x20.
        applyStimulus(1'b0, 1'b1, 32'h1C, 1'b0, 1'b0);
        idle();
        expectA("pre_stall", 32'h20, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            expectA("stall", 32'h20, 1'b1, 1'b0);
        end
        idle();
        expectA("post_stall", 32'h24, 1'b1, 1'b0);

        // Halt, redirect while halted, resume.
        applyStimulus(1'b0, 1'b1, 32'h3C, 1'b0, 1'b0);
        idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        expectA("halt", 32'h40, 1'b0, 1'b1);
        idle();
        expectA("halt_hold", 32'h40, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        expectA("halt_redir", 32'h200, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        expectA("resume", 32'h200, 1'b1, 1'b0);
        idle();
        expectA("resume_seq", 32'h204, 1'b1, 1'b0);

        // Redirect wins over stall, and stall holds inside the flush.
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
        expectA("stall_redir", 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        expectA("flush_stall", 32'h300, 1'b0, 1'b0);
        idle();
        expectA("flush_done", 32'h304, 1'b1, 1'b0);

        // Address wrap.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        expectA("wrap_redir", 32'hFFFF_FFFC, 1'b0, 1'b0);
        idle();
        expectA("wrap", 32'h0, 1'b1, 1'b0);

        // Resume and redirect together while halted.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 1'b1);
        expectA("resume_redir", 32'h500, 1'b0, 1'b0);
        idle();
        expectA("resume_redir_seq", 32'h504, 1'b1, 1'b0);

        // Misaligned redirect target.
        applyStimulus(1'b0, 1'b1, 32'h102, 1'b0, 1'b0);
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        expectA("misalign", 32'h504, 1'b0, 1'b1);
        checkOutput("misalign.fault", 32'(a_fault), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        expectA("misalign_resume", 32'h504, 1'b0, 1'b1);
        resetDut();
        checkOutput("misalign.cleared", 32'(a_fault), 32'd0);
`else
        expectA("unaligned_load", 32'h102, 1'b0, 1'b0);
        idle();
        expectA("unaligned_seq", 32'h106, 1'b1, 1'b0);
`endif

        // Controls are ignored during the boot cycle.
        resetDut();
        applyStimulus(1'b1, 1'b1, 32'h700, 1'b1, 1'b0);
        expectA("boot_ignore", 32'h0, 1'b0, 1'b0);
        idle();
        expectA("boot_ignore_seq", 32'h4, 1'b1, 1'b0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                resetDut();
            end else begin
                rpc = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF8;
                applyStimulus($urandom_range(0, 99) < 25,
                              $urandom_range(0, 99) < 15,
                              rpc,
                              $urandom_range(0, 99) < 8,
                              $urandom_range(0, 99) < 30);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
